dec_alu_stage: RTL and testbench

// - Decode stage and DEC->ALU pipeline register: decodes RV32I ORI/ADDI/ADD/SUB from fetch.
// - Reads the register file; drives dataSource1/dataSource2/immValue/op into the ALU.
// - Detects RAW hazards against the ALU and MEM stages: stalls fetch and inserts bubbles.
// - Honours downstream stall and branch flush.

---
 rtl/dec_alu_stage.sv | 278 +++++++++++++++++++++++++++
 tb/tb_dec_alu_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_alu_stage.sv
// ============================================================================
// Module  : dec_alu_stage
// Brief   : RV32I decode stage (ORI/ADDI/ADD/SUB) and DEC->ALU pipeline
//           register. Reads the register file, detects RAW hazards against
//           the ALU and MEM stages and stalls fetch with bubbles, honours
//           downstream stall and branch flush, counts hazard stall cycles.
//           Optional feature macro: DEC_ALU_FORWARDING_EN - resolves hazards
//           by forwarding ex_data / mem_data instead of stalling.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DataSize
`define DataSize 32
`endif
`ifndef ALUControlBus
`define ALUControlBus 3:0
`endif
`ifndef ALUop
`define ALUop 4'd0
`endif
`ifndef ALUop_ORI
`define ALUop_ORI 4'd1
`endif
`ifndef ALUop_ADDI
`define ALUop_ADDI 4'd2
`endif
`ifndef ALUop_ADD
`define ALUop_ADD 4'd3
`endif
`ifndef ALUop_SUB
`define ALUop_SUB 4'd4
`endif

module dec_alu_stage #(
  parameter int DW    = `DataSize,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch interface
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  output logic                  id_ready,
  // control
  input  logic                  flush,
  input  logic                  alu_stall,
  // register file
  output logic [AW-1:0]         rs1_addr,
  output logic [AW-1:0]         rs2_addr,
  input  logic [DW-1:0]         rs1_data,
  input  logic [DW-1:0]         rs2_data,
  // downstream destinations for hazard detection / forwarding
  input  logic [AW-1:0]         ex_rd_addr,
  input  logic                  ex_reg_write,
  input  logic [DW-1:0]         ex_data,
  input  logic [AW-1:0]         mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic [DW-1:0]         mem_data,
  // ALU-side registered outputs
  output logic [DW-1:0]         dataSource1,
  output logic [DW-1:0]         dataSource2,
  output logic [DW-1:0]         immValue,
  output logic [`ALUControlBus] op,
  output logic [AW-1:0]         rd_addr,
  output logic                  reg_write,
  output logic                  out_valid,
  output logic                  illegal_instr,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [6:0] c_OPC_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_REG = 7'b0110011;
  localparam logic [2:0] c_F3_ADD  = 3'b000;
  localparam logic [2:0] c_F3_OR   = 3'b110;
  localparam logic [6:0] c_F7_BASE = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_HAZ = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // instruction fields
  logic [6:0]           w_opcode;
  logic [2:0]           w_funct3;
  logic [6:0]           w_funct7;
  logic [AW-1:0]        w_rs1;
  logic [AW-1:0]        w_rs2;
  logic [AW-1:0]        w_rd;

  // decode results
  logic                 w_is_itype;
  logic                 w_is_rtype;
  logic                 w_legal;
  logic [`ALUControlBus] w_dec_op;
  logic [DW-1:0]        w_imm;
  logic [DW-1:0]        w_op1;
  logic [DW-1:0]        w_op2;

  // hazard / control
  logic                 w_use_rs1;
  logic                 w_use_rs2;
  logic                 w_rs1_ex;
  logic                 w_rs1_mem;
  logic                 w_rs2_ex;
  logic                 w_rs2_mem;
  logic                 w_hazard;
  logic                 w_hold;
  logic                 w_load_instr;
  logic                 w_cnt_en;

  // pipeline register
  logic [DW-1:0]        r_ds1;
  logic [DW-1:0]        r_ds2;
  logic [DW-1:0]        r_imm;
  logic [`ALUControlBus] r_op;
  logic [AW-1:0]        r_rd;
  logic                 r_reg_write;
  logic                 r_valid;
  logic                 r_illegal;
  logic [CNT_W-1:0]     r_stall_cnt;

  assign w_opcode = if_instr[6:0];
  assign w_funct3 = if_instr[14:12];
  assign w_funct7 = if_instr[31:25];
  assign w_rs1    = if_instr[19:15];
  assign w_rs2    = if_instr[24:20];
  assign w_rd     = if_instr[11:7];

  assign rs1_addr = w_rs1;
  assign rs2_addr = w_rs2;

  // Classify the fetched word into one of the four supported operations
  always_comb begin
    w_is_itype = 1'b0;
    w_is_rtype = 1'b0;
    w_dec_op   = `ALUop;
    if (w_opcode == c_OPC_IMM && w_funct3 == c_F3_OR) begin
      w_is_itype = 1'b1;
      w_dec_op   = `ALUop_ORI;
    end else if (w_opcode == c_OPC_IMM && w_funct3 == c_F3_ADD) begin
      w_is_itype = 1'b1;
      w_dec_op   = `ALUop_ADDI;
    end else if (w_opcode == c_OPC_REG && w_funct3 == c_F3_ADD && w_funct7 == c_F7_BASE) begin
      w_is_rtype = 1'b1;
      w_dec_op   = `ALUop_ADD;
    end else if (w_opcode == c_OPC_REG && w_funct3 == c_F3_ADD && w_funct7 == c_F7_ALT) begin
      w_is_rtype = 1'b1;
      w_dec_op   = `ALUop_SUB;
    end
  end

  assign w_legal = w_is_itype | w_is_rtype;
  assign w_imm   = {{(DW-12){if_instr[31]}}, if_instr[31:20]};

  // x0 never carries a dependency; rs2 only matters for register-register ops
  assign w_use_rs1 = w_legal & (w_rs1 != '0);
  assign w_use_rs2 = w_is_rtype & (w_rs2 != '0);

  assign w_rs1_ex  = w_use_rs1 & ex_reg_write  & (ex_rd_addr  == w_rs1);
  assign w_rs1_mem = w_use_rs1 & mem_reg_write & (mem_rd_addr == w_rs1);
  assign w_rs2_ex  = w_use_rs2 & ex_reg_write  & (ex_rd_addr  == w_rs2);
  assign w_rs2_mem = w_use_rs2 & mem_reg_write & (mem_rd_addr == w_rs2);

`ifdef DEC_ALU_FORWARDING_EN
  // The younger producer (ALU stage) wins when both stages target the same register
  assign w_hazard = 1'b0;
  assign w_op1    = w_rs1_ex ? ex_data : (w_rs1_mem ? mem_data : rs1_data);
  assign w_op2    = w_rs2_ex ? ex_data : (w_rs2_mem ? mem_data : rs2_data);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{ex_data, mem_data};
  assign w_hazard     = if_valid & (w_rs1_ex | w_rs1_mem | w_rs2_ex | w_rs2_mem);
  assign w_op1        = rs1_data;
  assign w_op2        = rs2_data;
`endif

  // Priority: flush beats downstream stall, which beats the hazard stall
  assign id_ready     = (~alu_stall & ~w_hazard) | flush;
  assign w_hold       = ~flush & alu_stall;
  assign w_load_instr = ~flush & ~alu_stall & ~w_hazard & if_valid;

  // Hazard FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hazard FSM next state and stall-count enable
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_en    = 1'b0;
    if (flush) begin
      w_state_nxt = ST_RUN;
    end else if (!alu_stall) begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard) begin
            w_state_nxt = ST_HAZ;
            w_cnt_en    = 1'b1;
          end
        end
        ST_HAZ: begin
          if (w_hazard) begin
            w_cnt_en = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // DEC->ALU register: hold on downstream stall, else load instruction or bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ds1       <= '0;
      r_ds2       <= '0;
      r_imm       <= '0;
      r_op        <= `ALUop;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_valid     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      if (w_load_instr) begin
        r_ds1       <= w_legal    ? w_op1 : '0;
        r_ds2       <= w_is_rtype ? w_op2 : '0;
        r_imm       <= w_is_itype ? w_imm : '0;
        r_op        <= w_dec_op;
        r_rd        <= w_legal ? w_rd : '0;
        r_reg_write <= w_legal & (w_rd != '0);
        r_valid     <= 1'b1;
        r_illegal   <= ~w_legal;
      end else if (!w_hold) begin
        r_ds1       <= '0;
        r_ds2       <= '0;
        r_imm       <= '0;
        r_op        <= `ALUop;
        r_rd        <= '0;
        r_reg_write <= 1'b0;
        r_valid     <= 1'b0;
      end
    end
  end

  // Saturating count of hazard stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_cnt_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign dataSource1   = r_ds1;
  assign dataSource2   = r_ds2;
  assign immValue      = r_imm;
  assign op            = r_op;
  assign rd_addr       = r_rd;
  assign reg_write     = r_reg_write;
  assign out_valid     = r_valid;
  assign illegal_instr = r_illegal;
  assign stall_cycles  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dec_alu_stage.sv
// ============================================================================
// Module  : tb_dec_alu_stage
// Brief   : Self-checking bench for dec_alu_stage: directed vector table,
//           hand-written corner sequences and randomized stimulus against a
//           behavioural model. Honours DEC_ALU_FORWARDING_EN if defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_alu_stage;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [3:0] OP_DEF  = 4'd0;
  localparam logic [3:0] OP_ORI  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;

  localparam logic [31:0] I_ADDI_1_2_M5 = 32'hFFB10093; // ADDI x1,x2,-5
  localparam logic [31:0] I_SUB_3_1_2   = 32'h402081B3; // SUB  x3,x1,x2
  localparam logic [31:0] I_ADD_3_1_2   = 32'h002081B3; // ADD  x3,x1,x2
  localparam logic [31:0] I_ORI_5_6     = 32'h7F036293; // ORI  x5,x6,0x7F0
  localparam logic [31:0] I_ECALL       = 32'h00000073;
  localparam logic [31:0] I_ORI_0_5_1   = 32'h0012E013; // ORI  x0,x5,1

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic if_valid, flush, alu_stall, ex_reg_write, mem_reg_write;
  logic [31:0] if_instr;
  logic [AW-1:0] ex_rd_addr, mem_rd_addr, rs1_addr, rs2_addr, rd_addr;
  logic [DW-1:0] rs1_data, rs2_data, ex_data, mem_data;
  logic [DW-1:0] dataSource1, dataSource2, immValue;
  logic [3:0] op;
  logic id_ready, reg_write, out_valid, illegal_instr;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  dec_alu_stage #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
    .flush(flush), .alu_stall(alu_stall),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_data(ex_data),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_data(mem_data),
    .dataSource1(dataSource1), .dataSource2(dataSource2), .immValue(immValue),
    .op(op), .rd_addr(rd_addr), .reg_write(reg_write), .out_valid(out_valid),
    .illegal_instr(illegal_instr), .stall_cycles(stall_cycles)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] ds1, ds2, imm;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, vld, ill;
  } outs_t;

  typedef struct packed {
    logic [31:0] instr, d1, d2, ds1, ds2, imm;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, ill;
  } vec_t;

  outs_t m_out, m_nxt;
  int    m_cnt, m_cnt_nxt;
  logic  m_rdy;
  logic  last_rdy;
  vec_t  vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic outs_t bubble();
    outs_t o;
    o = '0;
    o.op = OP_DEF;
    return o;
  endfunction

  // 0 = unsupported, 1 = ORI, 2 = ADDI, 3 = ADD, 4 = SUB
  function automatic int kind(input logic [31:0] w);
    if (w[6:0] == 7'h13 && w[14:12] == 3'd6) return 1;
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return 2;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h00) return 3;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h20) return 4;
    return 0;
  endfunction

  function automatic outs_t expect_instr(input int k, input logic [31:0] w,
                                         input logic [31:0] v1, input logic [31:0] v2);
    outs_t o;
    o = bubble();
    o.vld = 1'b1;
    if (k == 0) begin
      o.ill = 1'b1;
    end else begin
      o.op  = (k == 1) ? OP_ORI : (k == 2) ? OP_ADDI : (k == 3) ? OP_ADD : OP_SUB;
      o.ds1 = v1;
      o.rd  = w[11:7];
      o.rw  = (w[11:7] != 5'd0);
      if (k <= 2) o.imm = 32'(int'($signed(w[31:20])));
      else        o.ds2 = v2;
    end
    return o;
  endfunction

  // Next-cycle expectation from the current inputs
  task automatic model_eval();
    int k;
    logic [4:0] a1, a2;
    bit use1, use2, c1e, c1m, c2e, c2m, haz;
    logic [31:0] v1, v2;
    k    = kind(if_instr);
    a1   = if_instr[19:15];
    a2   = if_instr[24:20];
    use1 = (k != 0) && (a1 != 5'd0);
    use2 = (k >= 3) && (a2 != 5'd0);
    c1e  = use1 && ex_reg_write  && (ex_rd_addr  == a1);
    c1m  = use1 && mem_reg_write && (mem_rd_addr == a1);
    c2e  = use2 && ex_reg_write  && (ex_rd_addr  == a2);
    c2m  = use2 && mem_reg_write && (mem_rd_addr == a2);
`ifdef DEC_ALU_FORWARDING_EN
    haz = 1'b0;
    v1  = c1e ? ex_data : c1m ? mem_data : rs1_data;
    v2  = c2e ? ex_data : c2m ? mem_data : rs2_data;
`else
    haz = if_valid && (c1e || c1m || c2e || c2m);
    v1  = rs1_data;
    v2  = rs2_data;
`endif
    m_rdy     = (!alu_stall && !haz) || flush;
    m_cnt_nxt = m_cnt;
    if (flush) begin
      m_nxt = bubble();
    end else if (alu_stall) begin
      m_nxt     = m_out;
      m_nxt.ill = 1'b0;
    end else if (haz) begin
      m_nxt = bubble();
      if (m_cnt < CMAX) m_cnt_nxt = m_cnt + 1;
    end else if (if_valid) begin
      m_nxt = expect_instr(k, if_instr, v1, v2);
    end else begin
      m_nxt = bubble();
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".out_valid"},     32'(out_valid),     32'(m_out.vld));
    chk({tag, ".op"},            32'(op),            32'(m_out.op));
    chk({tag, ".dataSource1"},   dataSource1,        m_out.ds1);
    chk({tag, ".dataSource2"},   dataSource2,        m_out.ds2);
    chk({tag, ".immValue"},      immValue,           m_out.imm);
    chk({tag, ".rd_addr"},       32'(rd_addr),       32'(m_out.rd));
    chk({tag, ".reg_write"},     32'(reg_write),     32'(m_out.rw));
    chk({tag, ".illegal_instr"}, 32'(illegal_instr), 32'(m_out.ill));
    chk({tag, ".stall_cycles"},  32'(stall_cycles),  32'(m_cnt));
  endtask

  // Called just after an active edge with inputs already driven
  task automatic tick(input string tag);
    #2;
    model_eval();
    last_rdy = id_ready;
    chk({tag, ".id_ready"}, 32'(id_ready), 32'(m_rdy));
    chk({tag, ".rs_addr"}, 32'({rs2_addr, rs1_addr}), 32'({if_instr[24:20], if_instr[19:15]}));
    @(posedge clk);
    #1;
    m_out = m_nxt;
    m_cnt = m_cnt_nxt;
    chk_outs(tag);
  endtask

  task automatic set_idle();
    if_valid = 1'b0; if_instr = 32'h00000013; flush = 1'b0; alu_stall = 1'b0;
    ex_rd_addr = '0; ex_reg_write = 1'b0; ex_data = '0;
    mem_rd_addr = '0; mem_reg_write = 1'b0; mem_data = '0;
    rs1_data = '0; rs2_data = '0;
  endtask

  // Outputs must clear as soon as rst_n falls, without waiting for a clock
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    m_out = bubble();
    m_cnt = 0;
    chk_outs(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [31:0] instr, d1, d2, ds1, ds2, imm,
                              input logic [3:0] o, input logic [4:0] rd, input logic rw, ill);
    vec_t v;
    v.instr = instr; v.d1 = d1; v.d2 = d2; v.ds1 = ds1; v.ds2 = ds2; v.imm = imm;
    v.op = o; v.rd = rd; v.rw = rw; v.ill = ill;
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, r1, r2;
    logic [11:0] imm;
    int sel;
    rd  = 5'($urandom_range(0, 3));
    r1  = 5'($urandom_range(0, 3));
    r2  = 5'($urandom_range(0, 3));
    imm = 12'($urandom);
    sel = $urandom_range(0, 6);
    case (sel)
      0: return {imm, r1, 3'b110, rd, 7'h13};
      1: return {imm, r1, 3'b000, rd, 7'h13};
      2: return {7'h00, r2, r1, 3'b000, rd, 7'h33};
      3: return {7'h20, r2, r1, 3'b000, rd, 7'h33};
      4: return 32'h00000073;
      5: return {imm, r1, 3'b100, rd, 7'h13};
      default: return {7'h01, r2, r1, 3'b000, rd, 7'h33};
    endcase
  endfunction

  initial begin
    logic pending;
    int cnt_before;
    vt[0] = mk(I_ADDI_1_2_M5, 32'd10,  32'd0,   32'd10,    32'd0,   32'hFFFFFFFB, OP_ADDI, 5'd1,  1'b1, 1'b0);
    vt[1] = mk(I_ORI_5_6,     32'h1234, 32'd3,  32'h1234,  32'd0,   32'h000007F0, OP_ORI,  5'd5,  1'b1, 1'b0);
    vt[2] = mk(I_ADD_3_1_2,   32'd100, 32'd200, 32'd100,   32'd200, 32'd0,        OP_ADD,  5'd3,  1'b1, 1'b0);
    vt[3] = mk(I_SUB_3_1_2,   32'd5,   32'd9,   32'd5,     32'd9,   32'd0,        OP_SUB,  5'd3,  1'b1, 1'b0);
    vt[4] = mk(I_ECALL,       32'd1,   32'd2,   32'd0,     32'd0,   32'd0,        OP_DEF,  5'd0,  1'b0, 1'b1);
    vt[5] = mk(I_ORI_0_5_1,   32'hAA,  32'd0,   32'hAA,    32'd0,   32'd1,        OP_ORI,  5'd0,  1'b0, 1'b0);
    vt[6] = mk(32'h80000F93,  32'd0,   32'd0,   32'd0,     32'd0,   32'hFFFFF800, OP_ADDI, 5'd31, 1'b1, 1'b0);

    set_idle();
    #1;
    do_reset("reset");

    // Directed decode vectors, one per cycle, no hazards
    for (int i = 0; i < 7; i++) begin
      if_valid = 1'b1; if_instr = vt[i].instr; rs1_data = vt[i].d1; rs2_data = vt[i].d2;
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.op", i),  32'(op),            32'(vt[i].op));
      chk($sformatf("vec%0d.ds1", i), dataSource1,        vt[i].ds1);
      chk($sformatf("vec%0d.ds2", i), dataSource2,        vt[i].ds2);
      chk($sformatf("vec%0d.imm", i), immValue,           vt[i].imm);
      chk($sformatf("vec%0d.rd", i),  32'(rd_addr),       32'(vt[i].rd));
      chk($sformatf("vec%0d.rw", i),  32'(reg_write),     32'(vt[i].rw));
      chk($sformatf("vec%0d.ill", i), 32'(illegal_instr), 32'(vt[i].ill));
      chk($sformatf("vec%0d.vld", i), 32'(out_valid),     32'd1);
    end
    set_idle();
    tick("idle");
    chk("idle.out_valid", 32'(out_valid), 32'd0);

    // Illegal pulse lasts exactly one cycle
    if_valid = 1'b1; if_instr = I_ECALL;
    tick("ecall");
    chk("ecall.pulse", 32'(illegal_instr), 32'd1);
    set_idle();
    tick("ecall_after");
    chk("ecall.pulse_end", 32'(illegal_instr), 32'd0);

    // RAW hazard on rs1 from the ALU stage
    do_reset("reset2");
    if_valid = 1'b1; if_instr = I_SUB_3_1_2; rs1_data = 32'd5; rs2_data = 32'd9;
    ex_rd_addr = 5'd1; ex_reg_write = 1'b1; ex_data = 32'd7;
    tick("haz1");
`ifdef DEC_ALU_FORWARDING_EN
    chk("fwd.id_ready", 32'(last_rdy), 32'd1);
    chk("fwd.ds1", dataSource1, 32'd7);
    chk("fwd.stall_cycles", 32'(stall_cycles), 32'd0);
    ex_reg_write = 1'b0;
    tick("haz2");
`else
    chk("haz.id_ready", 32'(last_rdy), 32'd0);
    chk("haz.bubble", 32'(out_valid), 32'd0);
    chk("haz.stall_cycles", 32'(stall_cycles), 32'd1);
    ex_reg_write = 1'b0;
    tick("haz2");
    chk("haz.release_valid", 32'(out_valid), 32'd1);
    chk("haz.release_ds1", dataSource1, 32'd5);
    chk("haz.release_op", 32'(op), 32'(OP_SUB));
    chk("haz.stall_hold", 32'(stall_cycles), 32'd1);
`endif

    // Flush together with a hazard
    set_idle();
    if_valid = 1'b1; if_instr = I_ADDI_1_2_M5; rs1_data = 32'd10;
    tick("pre_flush");
    cnt_before = m_cnt;
    if_instr = I_SUB_3_1_2; ex_rd_addr = 5'd1; ex_reg_write = 1'b1; flush = 1'b1;
    tick("flush");
    chk("flush.id_ready", 32'(last_rdy), 32'd1);
    chk("flush.bubble", 32'(out_valid), 32'd0);
    chk("flush.stall_cycles", 32'(stall_cycles), 32'(cnt_before));
    flush = 1'b0; ex_reg_write = 1'b0;
    tick("post_flush");
    chk("post_flush.valid", 32'(out_valid), 32'd1);

    // Downstream stall holds the register
    set_idle();
    if_valid = 1'b1; if_instr = I_ADD_3_1_2; rs1_data = 32'd100; rs2_data = 32'd200;
    tick("pre_stall");
    alu_stall = 1'b1; if_instr = I_ORI_5_6; rs1_data = 32'd999;
    tick("stall");
    chk("stall.id_ready", 32'(last_rdy), 32'd0);
    chk("stall.hold_op", 32'(op), 32'(OP_ADD));
    chk("stall.hold_ds1", dataSource1, 32'd100);
    alu_stall = 1'b0;
    tick("post_stall");
    chk("post_stall.op", 32'(op), 32'(OP_ORI));

    // Reset while a valid instruction is in the register
    chk("midreset.pre_valid", 32'(out_valid), 32'd1);
    do_reset("midreset");
    chk("midreset.valid", 32'(out_valid), 32'd0);
    set_idle();
    if_valid = 1'b1; if_instr = I_ADDI_1_2_M5; rs1_data = 32'd10;
    tick("midreset_run");
    chk("midreset.run_valid", 32'(out_valid), 32'd1);

    // Long hazard drives the stall counter into saturation
    do_reset("reset3");
    if_valid = 1'b1; if_instr = I_SUB_3_1_2; mem_rd_addr = 5'd2; mem_reg_write = 1'b1;
    for (int i = 0; i < CMAX + 5; i++) tick("sat");
`ifdef DEC_ALU_FORWARDING_EN
    chk("sat.stall_cycles", 32'(stall_cycles), 32'd0);
`else
    chk("sat.stall_cycles", 32'(stall_cycles), 32'(CMAX));
`endif

    // Randomized traffic against the model
    do_reset("reset4");
    set_idle();
    pending = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!pending) begin
        if_valid = ($urandom_range(0, 3) != 0);
        if_instr = rand_instr();
      end
      flush         = ($urandom_range(0, 15) == 0);
      alu_stall     = ($urandom_range(0, 7) == 0);
      ex_rd_addr    = 5'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom_range(0, 1));
      mem_rd_addr   = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      rs1_data = $urandom; rs2_data = $urandom; ex_data = $urandom; mem_data = $urandom;
      tick("rnd");
      pending = if_valid && !last_rdy;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
